// File: rtl/fetch_pkg.sv
// Shared types and constants for the two-wide fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, MISS} fetch_state_e;
  localparam int FETCH_WIDTH = 2;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter; adds 0..2 per cycle and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W:0] sum;

  // One extra bit catches any step past all-ones.
  assign sum = {1'b0, count} + {{(CNT_W-1){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (!reset)          count <= '0;
    else if (sum[CNT_W]) count <= '1;
    else                 count <= sum[CNT_W-1:0];
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Two-wide fetch address sequencer: advances on hits, holds on stop,
// takes redirects and runs an i-cache miss refill handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                stop,
  input  logic [1:0]                          hit,
  input  logic                                redirect_valid,
  input  logic [XLEN-1:0]                     redirect_address,
  input  logic                                miss_done,
  output logic                                fetch_req,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0]    addresses,
  output logic                                miss_req,
  output logic [XLEN-1:0]                     miss_address,
  output logic [CNT_W-1:0]                    fetched_count,
  output logic [CNT_W-1:0]                    miss_count
);
  localparam logic [XLEN-1:0] STEP      = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] PAIR_STEP = XLEN'(FETCH_WIDTH * INSTR_BYTES);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            pend_valid;
  logic [XLEN-1:0] pend_addr;
  logic [XLEN-1:0] redirect_target;
  logic [1:0]      fetch_inc;
  logic [1:0]      miss_inc;

  // Redirect targets are forced to word alignment.
  assign redirect_target = redirect_address & ~XLEN'(3);

  assign addresses[0] = pc;
  assign addresses[1] = pc + STEP;
  assign fetch_req    = (state == RUN);
  assign miss_req     = (state == MISS);

  always_comb begin
    fetch_inc = 2'd0;
    miss_inc  = 2'd0;
    if (state == RUN && !redirect_valid && !stop) begin
      if (hit == 2'b11) begin
        fetch_inc = 2'd2;
      end else if (hit == 2'b01) begin
        fetch_inc = 2'd1;
        miss_inc  = 2'd1;
      end else if (!hit[0]) begin
        miss_inc  = 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= RESET_VECTOR;
      miss_address <= '0;
      pend_valid   <= 1'b0;
      pend_addr    <= '0;
    end else begin
      unique case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (redirect_valid) begin
            pc <= redirect_target;
          end else if (stop) begin
            pc <= pc;
          end else if (hit == 2'b11) begin
            pc <= pc + PAIR_STEP;
          end else if (hit == 2'b01) begin
            // Slot 0 delivered; the refill starts at slot 1.
            pc           <= pc + STEP;
            miss_address <= pc + STEP;
            state        <= MISS;
          end else if (!hit[0]) begin
            miss_address <= pc;
            state        <= MISS;
          end
        end
        MISS: begin
          if (miss_done) begin
            state      <= RUN;
            pend_valid <= 1'b0;
            if (redirect_valid)  pc <= redirect_target;
            else if (pend_valid) pc <= pend_addr;
          end else if (redirect_valid) begin
            pend_valid <= 1'b1;
            pend_addr  <= redirect_target;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_fetched_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (fetch_inc),
    .count (fetched_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_count)
  );
endmodule
